// File: rtl/mul_product_accumulator_if.sv
// Product-accumulator bus: the product input stream and the finished-sum output.
//
// Handshake rules (both directions): a transfer happens on a rising clock edge
// where valid and ready are both 1. Payload travels with valid and must stay
// stable while valid=1 and ready=0. Ready may depend on state but never on the
// same-cycle valid.
interface mul_product_accumulator_if #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] term_count;
    logic             overflow;

    // Upstream multiplier plus downstream consumer side.
    modport master (
        output in_valid, product, in_last, out_ready,
        input  in_ready, out_valid, acc_sum, term_count, overflow
    );

    // Accumulator side.
    modport slave (
        input  in_valid, product, in_last, out_ready,
        output in_ready, out_valid, acc_sum, term_count, overflow
    );
endinterface

// File: rtl/mul_product_accumulator.sv
// Accumulates a run of 64-bit unsigned products into a wide sum, then holds the
// sum with its term count and a sticky carry-out flag until it is consumed.
// A sum ends on in_last or after MAX_TERMS products.
module mul_product_accumulator #(
    parameter  int ACC_W     = 72,
    parameter  int MAX_TERMS = 256,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    mul_product_accumulator_if.slave bus,
    output logic                     state_dbg
);
    // Zero bits needed to extend a product to ACC_W+1 (sum plus carry).
    localparam int PAD = ACC_W + 1 - 64;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_next;
    logic             sum_done;

    // Datapath for the product being accepted this cycle.
    always_comb begin
        accept   = bus.in_valid & in_ready_q;
        sum_ext  = {1'b0, acc_q} + {{PAD{1'b0}}, bus.product};
        cnt_next = cnt_q + CNT_W'(1);
        sum_done = bus.in_last | (cnt_next == CNT_W'(MAX_TERMS));
    end

    // Sum state machine; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            // Clear wins over any accept or pending output.
            state       <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_q <= sum_ext[ACC_W-1:0];
                        cnt_q <= cnt_next;
                        ovf_q <= ovf_q | sum_ext[ACC_W];
                        if (sum_done) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.acc_sum    = acc_q;
    assign bus.term_count = cnt_q;
    assign bus.overflow   = ovf_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_mul_product_accumulator.sv
// Bench for mul_product_accumulator: a default-sized instance (72-bit sum,
// 256 terms) and a small instance (64-bit sum, 4 terms) for auto-termination
// and carry-out cases. Expected sums come from unbounded 128-bit arithmetic.
module tb_mul_product_accumulator;
    logic clk;
    logic rst;
    logic clr_a;
    logic clr_b;
    logic dbg_a;
    logic dbg_b;
    int   errors;
    int   checks;

    mul_product_accumulator_if #(.ACC_W(72), .CNT_W(9)) ifa ();
    mul_product_accumulator_if #(.ACC_W(64), .CNT_W(3)) ifb ();

    mul_product_accumulator u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_a),
        .bus       (ifa.slave),
        .state_dbg (dbg_a)
    );

    mul_product_accumulator #(.ACC_W(64), .MAX_TERMS(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_b),
        .bus       (ifb.slave),
        .state_dbg (dbg_b)
    );

    // Clock: period 10, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one product to instance A at a falling edge; it is taken at the next rising edge.
    task automatic push_a(input logic [63:0] p, input logic last);
        chk("a_in_ready_push", 128'(ifa.in_ready), 128'(1));
        ifa.in_valid = 1'b1;
        ifa.product  = p;
        ifa.in_last  = last;
        @(negedge clk);
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
    endtask

    task automatic push_b(input logic [63:0] p, input logic last);
        chk("b_in_ready_push", 128'(ifb.in_ready), 128'(1));
        ifb.in_valid = 1'b1;
        ifb.product  = p;
        ifb.in_last  = last;
        @(negedge clk);
        ifb.in_valid = 1'b0;
        ifb.in_last  = 1'b0;
    endtask

    // Consume the held sum and confirm the block is empty and ready again.
    task automatic release_a();
        ifa.out_ready = 1'b1;
        @(negedge clk);
        ifa.out_ready = 1'b0;
        chk("a_rel_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("a_rel_in_ready", 128'(ifa.in_ready), 128'(1));
        chk("a_rel_acc", 128'(ifa.acc_sum), 128'(0));
        chk("a_rel_cnt", 128'(ifa.term_count), 128'(0));
        chk("a_rel_ovf", 128'(ifa.overflow), 128'(0));
    endtask

    task automatic release_b();
        ifb.out_ready = 1'b1;
        @(negedge clk);
        ifb.out_ready = 1'b0;
        chk("b_rel_out_valid", 128'(ifb.out_valid), 128'(0));
        chk("b_rel_in_ready", 128'(ifb.in_ready), 128'(1));
        chk("b_rel_acc", 128'(ifb.acc_sum), 128'(0));
        chk("b_rel_ovf", 128'(ifb.overflow), 128'(0));
    endtask

    task automatic expect_a(input string tag, input logic [127:0] total, input int n);
        chk({tag, "_out_valid"}, 128'(ifa.out_valid), 128'(1));
        chk({tag, "_in_ready"}, 128'(ifa.in_ready), 128'(0));
        chk({tag, "_acc"}, 128'(ifa.acc_sum), 128'(total[71:0]));
        chk({tag, "_cnt"}, 128'(ifa.term_count), 128'(n));
        chk({tag, "_ovf"}, 128'(ifa.overflow), 128'((total >> 72) != 0));
        chk({tag, "_dbg"}, 128'(dbg_a), 128'(1));
    endtask

    task automatic expect_b(input string tag, input logic [127:0] total, input int n);
        chk({tag, "_out_valid"}, 128'(ifb.out_valid), 128'(1));
        chk({tag, "_in_ready"}, 128'(ifb.in_ready), 128'(0));
        chk({tag, "_acc"}, 128'(ifb.acc_sum), 128'(total[63:0]));
        chk({tag, "_cnt"}, 128'(ifb.term_count), 128'(n));
        chk({tag, "_ovf"}, 128'(ifb.overflow), 128'((total >> 64) != 0));
    endtask

    initial begin
        logic [127:0] total;
        logic [63:0]  p;
        int           len;
        logic         last;

        errors = 0;
        checks = 0;
        rst    = 1'b0;
        clr_a  = 1'b0;
        clr_b  = 1'b0;
        ifa.in_valid = 1'b0; ifa.product = '0; ifa.in_last = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.product = '0; ifb.in_last = 1'b0; ifb.out_ready = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_acc", 128'(ifa.acc_sum), 128'(0));
        chk("rst_cnt", 128'(ifa.term_count), 128'(0));
        chk("rst_ovf", 128'(ifa.overflow), 128'(0));
        chk("rst_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("rst_in_ready", 128'(ifa.in_ready), 128'(1));
        chk("rst_b_out_valid", 128'(ifb.out_valid), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(ifa.in_ready), 128'(1));
        chk("post_rst_dbg", 128'(dbg_a), 128'(0));

        // Basic sum: 36+15+14+16 = 81, visible one cycle after the last accept.
        push_a(64'd36, 1'b0);
        push_a(64'd15, 1'b0);
        push_a(64'd14, 1'b0);
        push_a(64'd16, 1'b1);
        expect_a("basic", 128'd81, 4);

        // Backpressure: held sum ignores incoming products.
        ifa.in_valid = 1'b1;
        ifa.product  = 64'd99;
        repeat (5) begin
            @(negedge clk);
            chk("bp_acc", 128'(ifa.acc_sum), 128'd81);
            chk("bp_cnt", 128'(ifa.term_count), 128'd4);
            chk("bp_in_ready", 128'(ifa.in_ready), 128'(0));
            chk("bp_out_valid", 128'(ifa.out_valid), 128'(1));
        end
        ifa.in_valid = 1'b0;
        release_a();
        push_a(64'd7, 1'b1);
        expect_a("after_bp", 128'd7, 1);
        release_a();

        // clr together with an accept discards both the partial sum and the product.
        push_a(64'd0, 1'b0);
        push_a(64'd5, 1'b0);
        chk("clr_pre_acc", 128'(ifa.acc_sum), 128'd5);
        clr_a = 1'b1;
        ifa.in_valid = 1'b1;
        ifa.product  = 64'd7;
        @(negedge clk);
        clr_a = 1'b0;
        ifa.in_valid = 1'b0;
        chk("clr_acc", 128'(ifa.acc_sum), 128'(0));
        chk("clr_cnt", 128'(ifa.term_count), 128'(0));
        chk("clr_in_ready", 128'(ifa.in_ready), 128'(1));
        push_a(64'd3, 1'b1);
        expect_a("after_clr", 128'd3, 1);
        // clr in HOLD drops the held sum without a handshake.
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("clr_hold_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("clr_hold_in_ready", 128'(ifa.in_ready), 128'(1));
        chk("clr_hold_acc", 128'(ifa.acc_sum), 128'(0));

        // Asynchronous reset mid-sum, between clock edges.
        push_a(64'd20, 1'b0);
        chk("ar_pre_acc", 128'(ifa.acc_sum), 128'd20);
        #2 rst = 1'b0;
        #1;
        chk("ar_acc", 128'(ifa.acc_sum), 128'(0));
        chk("ar_cnt", 128'(ifa.term_count), 128'(0));
        chk("ar_out_valid", 128'(ifa.out_valid), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar_in_ready", 128'(ifa.in_ready), 128'(1));
        push_a(64'd36, 1'b1);
        expect_a("ar_fresh", 128'd36, 1);
        // Asynchronous reset in HOLD drops out_valid without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk("ar_hold_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("ar_hold_acc", 128'(ifa.acc_sum), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Small instance: auto-terminate at 4 terms without in_last.
        push_b(64'd1, 1'b0);
        push_b(64'd2, 1'b0);
        push_b(64'd3, 1'b0);
        push_b(64'd4, 1'b0);
        expect_b("auto", 128'd10, 4);
        ifb.in_valid = 1'b1;
        ifb.product  = 64'd5;
        repeat (2) begin
            @(negedge clk);
            chk("auto_stall_in_ready", 128'(ifb.in_ready), 128'(0));
            chk("auto_stall_acc", 128'(ifb.acc_sum), 128'd10);
            chk("auto_stall_cnt", 128'(ifb.term_count), 128'd4);
        end
        ifb.in_valid = 1'b0;
        release_b();

        // Small instance: carry out of 64 bits sets overflow, cleared with the sum.
        push_b(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        push_b(64'd2, 1'b1);
        expect_b("ovf", 128'h1_0000_0000_0000_0001, 2);
        release_b();
        push_b(64'd5, 1'b1);
        expect_b("ovf_next", 128'd5, 1);
        release_b();

        // Randomized sums on the default instance.
        for (int s = 0; s < 12; s++) begin
            len   = $urandom_range(1, 8);
            total = '0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 1) p = {$urandom, $urandom};
                else                           p = 64'($urandom_range(0, 1000));
                total = total + 128'(p);
                push_a(p, i == len - 1);
                if (i != len - 1) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clk);
                        chk("rnd_a_gap_acc", 128'(ifa.acc_sum), total);
                    end
                end
            end
            expect_a("rnd_a", total, len);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rnd_a_hold_acc", 128'(ifa.acc_sum), 128'(total[71:0]));
            end
            release_a();
        end

        // Randomized sums on the small instance; large products make carries common.
        for (int s = 0; s < 12; s++) begin
            len   = $urandom_range(1, 4);
            total = '0;
            for (int i = 0; i < len; i++) begin
                p = {$urandom, $urandom};
                total = total + 128'(p);
                if (i != len - 1)  last = 1'b0;
                else if (len < 4)  last = 1'b1;
                else               last = 1'($urandom_range(0, 1));
                push_b(p, last);
            end
            expect_b("rnd_b", total, len);
            release_b();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
